stage2_pow2_approx: RTL and testbench
=====================================

// Module: stage2_pow2_approx
// PURPOSE
//  Second stage of the Q8.8 softmax-approximation pipeline. Sits directly downstream of
//  stage1_log2_approx and takes its log_in_0 / in_0_bypass / in_1_bypass / valid_out.
//  Computes d = in_1 - log2(in_0) and the piecewise-linear approximation 2^d in Q8.8.
//  Two register stages; a common clock enable stalls the whole pipeline.
// PARAMETERS
//  W      16  data width, signed Q8.8 (fixed; no other value is supported)
//  FRAC    8  fraction bits of the Q format
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  en           in   1   clock enable / stall; 0 = every register holds
//  valid_in     in   1   qualifies log_in_0, in_0_bypass, in_1_bypass (stage1 valid_out)
//  log_in_0     in   16  log2(in_0), signed Q8.8
//  in_0_bypass  in   16  in_0 from stage1, pipelined alongside the result
//  in_1_bypass  in   16  in_1 from stage1, signed Q8.8
//  valid_out    out  1   result valid
//  pow_out      out  16  2^(in_1 - log_in_0), unsigned Q8.8 in 0x0000..0x7FFF
//  in_0_aligned out  16  in_0_bypass delayed to line up with pow_out
//  in_1_aligned out  16  in_1_bypass delayed to line up with pow_out
// BEHAVIOUR
//  - Reset (async, rst=1): every register and output goes to 0, including valid_out.
//    Reset also applies mid-operation and drops in-flight data; the first valid_out
//    after rst falls comes no earlier than 2 enabled edges after a new valid_in.
//  - Stalls: a register updates only on a rising edge with en=1. With en=0 all state
//    holds, valid_out included, and valid_in is ignored.
//  - Latency: 2 enabled edges from valid_in to valid_out. Throughput is 1 per enabled edge.
//    Data registers load every enabled edge whatever valid_in is. valid_out is a pure
//    2-deep shift of valid_in.
//  - Stage A, on an enabled edge:
//      diff_full = sext17(in_1_bypass) - sext17(log_in_0)
//      Saturate to 16 bits: > 0x7FFF gives 0x7FFF; < -0x8000 gives 0x8000.
//      Register diff, in_0_bypass, in_1_bypass and valid_in.
//  - Stage B, on an enabled edge, with I = signed diff[15:8] and f = diff[7:8-8]:
//      m = {1'b1, f}, 9 bits, representing (1 + f/256) in Q8.8 (256..511).
//      0 <= I <= 6        : pow_out = m << I  (max 511<<6 = 0x7FC0; no overflow)
//      I >= 7             : pow_out = 16'h7FFF (saturate)
//      -8 <= I <= -1      : pow_out = m >> (-I), truncate (floor)
//      I <= -9            : pow_out = 0
//      pow_out[15] is always 0.
//  - Aligned outputs: in_0_aligned and in_1_aligned take the stage-A copies on the same
//    edge that pow_out loads.
//  - Back-to-back valid_in with no gaps gives back-to-back valid_out; no bubbles are
//    inserted or removed.
//  - No combinational path from any input to any output.
// TESTING
//  T1: rst pulse, then log_in_0=0x0200, in_1=0x0300, valid 1 cycle
//      -> 2 edges later valid_out=1, pow_out=0x0200, then valid_out=0.
//  T2: back-to-back diffs {0x0180, 0xFF00, 0xFF80, 0x0000} (log_in_0=0)
//      -> consecutive pow_out {0x0300, 0x0080, 0x00C0, 0x0100}; valid_out high 4 cycles.
//  T3: saturation with in_1=0x7F00, log_in_0=0x8000 -> pow_out=0x7FFF.
//      Underflow with in_1=0x8000, log_in_0=0x7F00 -> pow_out=0x0000.
//      diff=0x0700 -> 0x7FFF; diff=0xF700 -> 0x0000.
//  T4: stall by dropping en for 3 cycles while data is in stage A
//      -> valid_out/pow_out/aligned outputs frozen. Resumes after en=1; result emerges
//      exactly 2 enabled edges after valid_in.
//  T5: assert rst asynchronously mid-cycle with 2 items in flight
//      -> outputs 0 immediately with no clock; no stale valid_out after release.
//  T6: random sweep against a reference model of the formula above, over all boundary
//      I values -9..7 -> bit-exact match; in_0/in_1_aligned equal the inputs 2 edges earlier.

Source files
------------

// File: rtl/stage2_pow2_approx.sv
// Second stage of the Q8.8 softmax approximation: d = in_1 - log2(in_0), then a
// piecewise-linear 2^d in Q8.8. Two register stages under a shared clock enable.
module stage2_pow2_approx #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid_in,
  input  logic [W-1:0] log_in_0,
  input  logic [W-1:0] in_0_bypass,
  input  logic [W-1:0] in_1_bypass,
  output logic         valid_out,
  output logic [W-1:0] pow_out,
  output logic [W-1:0] in_0_aligned,
  output logic [W-1:0] in_1_aligned
);

  logic [1:0]      vld_pipe_d, vld_pipe_q;
  logic [W-1:0]    diff_d, diff_q;
  logic [W-1:0]    in0_a_d, in0_a_q, in1_a_d, in1_a_q;
  logic [W-1:0]    pow_d, pow_q;
  logic [W-1:0]    in0_b_d, in0_b_q, in1_b_d, in1_b_q;

  logic [W:0]      diff_full;
  logic [W-FRAC-1:0] int_part;
  logic [FRAC:0]   mant;
  logic [3:0]      rsh;

  // Stage A: 17-bit difference, saturated back into 16 bits
  always_comb begin
    diff_full = {in_1_bypass[W-1], in_1_bypass} - {log_in_0[W-1], log_in_0};
    diff_d    = diff_full[W-1:0];
    if (diff_full[W] != diff_full[W-1])
      diff_d = diff_full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    in0_a_d = in_0_bypass;
    in1_a_d = in_1_bypass;
  end

  // Stage B: integer part selects shift direction, fraction forms the 1.f mantissa
  always_comb begin
    int_part = diff_q[W-1:FRAC];
    mant     = {1'b1, diff_q[FRAC-1:0]};
    rsh      = 4'(~int_part[3:0] + 4'd1);
    pow_d    = '0;
    if (!int_part[W-FRAC-1]) begin
      if (int_part[W-FRAC-2:0] > 7'd6)
        pow_d = {1'b0, {(W-1){1'b1}}};
      else
        pow_d = {{(W-FRAC-1){1'b0}}, mant} << int_part[2:0];
    end else if (int_part[W-FRAC-1:3] == 5'b11111) begin
      pow_d = {{(W-FRAC-1){1'b0}}, mant} >> rsh;
    end
    in0_b_d    = in0_a_q;
    in1_b_d    = in1_a_q;
    vld_pipe_d = {vld_pipe_q[0], valid_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      diff_q     <= '0;
      in0_a_q    <= '0;
      in1_a_q    <= '0;
      pow_q      <= '0;
      in0_b_q    <= '0;
      in1_b_q    <= '0;
    end else if (en) begin
      vld_pipe_q <= vld_pipe_d;
      diff_q     <= diff_d;
      in0_a_q    <= in0_a_d;
      in1_a_q    <= in1_a_d;
      pow_q      <= pow_d;
      in0_b_q    <= in0_b_d;
      in1_b_q    <= in1_b_d;
    end
  end

  assign valid_out    = vld_pipe_q[1];
  assign pow_out      = pow_q;
  assign in_0_aligned = in0_b_q;
  assign in_1_aligned = in1_b_q;

endmodule

// File: tb/tb_stage2_pow2_approx.sv
// Directed bench for stage2_pow2_approx: reset, latency, saturation, stall,
// async reset and a boundary sweep against an arithmetic reference.
module tb_stage2_pow2_approx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] log_in_0 = '0, in_0_bypass = '0, in_1_bypass = '0;
  logic        valid_out;
  logic [15:0] pow_out, in_0_aligned, in_1_aligned;

  int n_cmp = 0;
  int n_err = 0;

  stage2_pow2_approx dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in),
    .log_in_0(log_in_0), .in_0_bypass(in_0_bypass), .in_1_bypass(in_1_bypass),
    .valid_out(valid_out), .pow_out(pow_out),
    .in_0_aligned(in_0_aligned), .in_1_aligned(in_1_aligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] lg, input logic [15:0] i0,
                       input logic [15:0] i1);
    valid_in    = v;
    log_in_0    = lg;
    in_0_bypass = i0;
    in_1_bypass = i1;
  endtask

  function automatic logic [15:0] pow_ref(input logic [15:0] i1, input logic [15:0] lg);
    int d, ip, f;
    d = int'($signed(i1)) - int'($signed(lg));
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    ip = d >>> 8;
    f  = d & 255;
    if (ip >= 7)       return 16'h7FFF;
    else if (ip >= 0)  return 16'((256 + f) << ip);
    else if (ip >= -8) return 16'((256 + f) >> (-ip));
    else               return 16'h0000;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'h1111, 16'h2222, 16'h3333);
    step();
    step();
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got %h want 0", valid_out); end
    n_cmp++; if (pow_out !== 16'h0) begin n_err++; $display("FAIL reset_pow got %h want 0000", pow_out); end
    n_cmp++; if (in_0_aligned !== 16'h0) begin n_err++; $display("FAIL reset_in0 got %h want 0000", in_0_aligned); end
    n_cmp++; if (in_1_aligned !== 16'h0) begin n_err++; $display("FAIL reset_in1 got %h want 0000", in_1_aligned); end
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_latency();
    drive(1'b1, 16'h0200, 16'h0055, 16'h0300);
    step();
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL lat_early got %h want 0", valid_out); end
    step();
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL lat_valid got %h want 1", valid_out); end
    n_cmp++; if (pow_out !== 16'h0200) begin n_err++; $display("FAIL lat_pow got %h want 0200", pow_out); end
    n_cmp++; if (in_0_aligned !== 16'h0055) begin n_err++; $display("FAIL lat_in0 got %h want 0055", in_0_aligned); end
    step();
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL lat_drop got %h want 0", valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] dv [4] = '{16'h0180, 16'hFF00, 16'hFF80, 16'h0000};
    logic [15:0] ev [4] = '{16'h0300, 16'h0080, 16'h00C0, 16'h0100};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, 16'h0000, 16'(i), dv[i]);
      else       drive(1'b0, 16'h0, 16'h0, 16'h0);
      step();
      if (i >= 1) begin
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got %h want 1", i-1, valid_out); end
        n_cmp++; if (pow_out !== ev[i-1]) begin n_err++; $display("FAIL b2b_pow[%0d] got %h want %h", i-1, pow_out, ev[i-1]); end
        n_cmp++; if (in_1_aligned !== dv[i-1]) begin n_err++; $display("FAIL b2b_in1[%0d] got %h want %h", i-1, in_1_aligned, dv[i-1]); end
      end
    end
    step();
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL b2b_tail got %h want 0", valid_out); end
  endtask

  task automatic test_saturation();
    logic [15:0] i1v [6] = '{16'h7F00, 16'h8000, 16'h0700, 16'hF700, 16'hF800, 16'h06FF};
    logic [15:0] lgv [6] = '{16'h8000, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] ev  [6] = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h0001, 16'h7FC0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, lgv[i], 16'h0, i1v[i]);
      step();
      drive(1'b0, 16'h0, 16'h0, 16'h0);
      step();
      n_cmp++; if (pow_out !== ev[i]) begin n_err++; $display("FAIL sat_pow[%0d] got %h want %h", i, pow_out, ev[i]); end
    end
    step();
    step();
  endtask

  task automatic test_stall();
    drive(1'b0, 16'h0000, 16'hAAAA, 16'h0080);
    step();
    drive(1'b1, 16'h0000, 16'h1234, 16'h0100);
    step();
    en = 1'b0;
    drive(1'b1, 16'h4000, 16'h5555, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL stall_valid[%0d] got %h want 0", i, valid_out); end
      n_cmp++; if (pow_out !== 16'h0180) begin n_err++; $display("FAIL stall_pow[%0d] got %h want 0180", i, pow_out); end
      n_cmp++; if (in_0_aligned !== 16'hAAAA) begin n_err++; $display("FAIL stall_in0[%0d] got %h want AAAA", i, in_0_aligned); end
    end
    en = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    step();
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL stall_resume_valid got %h want 1", valid_out); end
    n_cmp++; if (pow_out !== 16'h0200) begin n_err++; $display("FAIL stall_resume_pow got %h want 0200", pow_out); end
    n_cmp++; if (in_0_aligned !== 16'h1234) begin n_err++; $display("FAIL stall_resume_in0 got %h want 1234", in_0_aligned); end
    n_cmp++; if (in_1_aligned !== 16'h0100) begin n_err++; $display("FAIL stall_resume_in1 got %h want 0100", in_1_aligned); end
    step();
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL stall_tail got %h want 0", valid_out); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'h0000, 16'h0A0A, 16'h0100);
    step();
    drive(1'b1, 16'h0000, 16'h0B0B, 16'h0200);
    step();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL arst_valid got %h want 0", valid_out); end
    n_cmp++; if (pow_out !== 16'h0) begin n_err++; $display("FAIL arst_pow got %h want 0000", pow_out); end
    n_cmp++; if (in_0_aligned !== 16'h0) begin n_err++; $display("FAIL arst_in0 got %h want 0000", in_0_aligned); end
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL arst_stale[%0d] got %h want 0", i, valid_out); end
    end
    drive(1'b1, 16'h0000, 16'h0C0C, 16'h0000);
    step();
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL arst_new_early got %h want 0", valid_out); end
    step();
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL arst_new_valid got %h want 1", valid_out); end
    n_cmp++; if (pow_out !== 16'h0100) begin n_err++; $display("FAIL arst_new_pow got %h want 0100", pow_out); end
    step();
  endtask

  task automatic test_sweep();
    logic [15:0] lg, i0, i1, exp_p;
    int d;
    for (int k = 0; k < 51; k++) begin
      if (k < 17) begin
        d  = (k - 9) * 256 + int'($urandom_range(0, 255));
        lg = 16'($signed(int'($urandom_range(0, 4000)) - 2000));
        i1 = 16'(d + int'($signed(lg)));
      end else begin
        lg = 16'($urandom);
        i1 = 16'($urandom);
      end
      i0    = 16'($urandom);
      exp_p = pow_ref(i1, lg);
      drive(1'b1, lg, i0, i1);
      step();
      drive(1'b0, 16'h0, 16'h0, 16'h0);
      step();
      n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL sweep_valid[%0d] got %h want 1", k, valid_out); end
      n_cmp++; if (pow_out !== exp_p) begin n_err++; $display("FAIL sweep_pow[%0d] i1=%h lg=%h got %h want %h", k, i1, lg, pow_out, exp_p); end
      n_cmp++; if (in_0_aligned !== i0) begin n_err++; $display("FAIL sweep_in0[%0d] got %h want %h", k, in_0_aligned, i0); end
      n_cmp++; if (in_1_aligned !== i1) begin n_err++; $display("FAIL sweep_in1[%0d] got %h want %h", k, in_1_aligned, i1); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_saturation();
    test_stall();
    test_async_reset();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
